// File: rtl/ins_pkg.sv
// Shared constants and FSM encoding for the instruction-buffer loader.
package ins_pkg;

    localparam int unsigned Depth = 128;
    localparam int unsigned AddrW = 7;
    localparam int unsigned CntW  = AddrW + 1;

    // ADDI x0,x0,0
    localparam logic [31:0] NopWord = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StLoad  = 2'd2,
        StDone  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/ins_loader_if.sv
// Byte-stream input and buffer write port of the loader, grouped as one bundle.
interface ins_loader_if
    import ins_pkg::*;
();

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             wr_en;
    logic [AddrW-1:0] wr_addr;
    logic [31:0]      wr_data;

    // Master is the loader: it consumes the byte stream and drives the buffer write port.
    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word; flags the word on the 4th byte.
module byte_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [7:0]  data_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] asm_q, asm_d;

    always_comb begin
        lane_d = lane_q;
        asm_d  = asm_q;
        if (clear_i) begin
            lane_d = 2'd0;
            asm_d  = 24'd0;
        end else if (valid_i) begin
            lane_d = lane_q + 2'd1;
            unique case (lane_q)
                2'd0:    asm_d[7:0]   = data_i;
                2'd1:    asm_d[15:8]  = data_i;
                2'd2:    asm_d[23:16] = data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= 2'd0;
            asm_q  <= 24'd0;
        end else begin
            lane_q <= lane_d;
            asm_q  <= asm_d;
        end
    end

    // The top byte bypasses the register so the word is complete in the 4th-byte cycle.
    assign word_valid_o = valid_i & ~clear_i & (lane_q == 2'd3);
    assign word_o       = {data_i, asm_q};

endmodule

// File: rtl/ins_loader.sv
// Clears the instruction buffer to NOP, then writes a byte-streamed program into it.
module ins_loader
    import ins_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [31:0]     base_i,
    input  logic [CntW-1:0] num_words_i,
    ins_loader_if.master    bus_io,
    output logic [31:0]     pc_base_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_overflow_o,
    output logic            err_align_o
);

    ld_state_e        state_q, state_d;
    logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;
    logic [CntW-1:0]  word_cnt_q, word_cnt_d;
    logic [CntW-1:0]  target_q, target_d;
    logic [31:0]      base_q, base_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_align_q, err_align_d;
    logic             wr_en_q, wr_en_d;
    logic [AddrW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic             start_acc;
    logic             byte_hs;
    logic             word_valid;
    logic [31:0]      word;

    assign start_acc = start_i & ((state_q == StIdle) | (state_q == StDone));
    assign byte_hs   = bus_io.byte_valid & (state_q == StLoad);

    byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (start_acc),
        .valid_i      (byte_hs),
        .data_i       (bus_io.byte_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        word_cnt_d  = word_cnt_q;
        target_d    = target_q;
        base_d      = base_q;
        err_ovf_d   = err_ovf_q;
        err_align_d = err_align_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_acc) begin
                    state_d     = StClear;
                    base_d      = {base_i[31:2], 2'b00};
                    err_align_d = |base_i[1:0];
                    err_ovf_d   = num_words_i > CntW'(Depth);
                    target_d    = (num_words_i > CntW'(Depth)) ? CntW'(Depth) : num_words_i;
                    clr_cnt_d   = '0;
                    word_cnt_d  = '0;
                end
            end
            StClear: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = NopWord;
                clr_cnt_d = clr_cnt_q + AddrW'(1);
                if (clr_cnt_q == AddrW'(Depth - 1)) begin
                    state_d = (target_q == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (word_valid && (word_cnt_q < target_q)) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = word_cnt_q[AddrW-1:0];
                    wr_data_d  = word;
                    word_cnt_d = word_cnt_q + CntW'(1);
                    if (word_cnt_q == target_q - CntW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clr_cnt_q   <= '0;
            word_cnt_q  <= '0;
            target_q    <= '0;
            base_q      <= '0;
            err_ovf_q   <= 1'b0;
            err_align_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            clr_cnt_q   <= clr_cnt_d;
            word_cnt_q  <= word_cnt_d;
            target_q    <= target_d;
            base_q      <= base_d;
            err_ovf_q   <= err_ovf_d;
            err_align_q <= err_align_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus_io.byte_ready = (state_q == StLoad);
    assign bus_io.wr_en      = wr_en_q;
    assign bus_io.wr_addr    = wr_addr_q;
    assign bus_io.wr_data    = wr_data_q;

    assign pc_base_o      = base_q;
    assign busy_o         = (state_q == StClear) | (state_q == StLoad);
    assign done_o         = (state_q == StDone);
    assign err_overflow_o = err_ovf_q;
    assign err_align_o    = err_align_q;

endmodule

// File: tb/tb_ins_loader.sv
// Directed bench for ins_loader: clear sweep, byte packing, gaps, clamping, restart and reset.
module tb_ins_loader;
    import ins_pkg::*;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            start = 1'b0;
    logic [31:0]     base = '0;
    logic [CntW-1:0] num = '0;
    logic [31:0]     pc_base;
    logic            busy, done, err_ovf, err_align;

    ins_loader_if bus ();

    ins_loader dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start),
        .base_i         (base),
        .num_words_i    (num),
        .bus_io         (bus),
        .pc_base_o      (pc_base),
        .busy_o         (busy),
        .done_o         (done),
        .err_overflow_o (err_ovf),
        .err_align_o    (err_align)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Write-port log, sampled on the falling edge.
    logic [AddrW-1:0] log_a[$];
    logic [31:0]      log_d[$];

    always @(negedge clk) begin
        if (rst_ni && bus.wr_en) begin
            log_a.push_back(bus.wr_addr);
            log_d.push_back(bus.wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [31:0] b, input int unsigned n);
        base  = b;
        num   = n[CntW-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [7:0] tx_q[$];

    // Streams tx_q; checks each word write appears right after its 4th byte.
    task automatic send(input bit gap);
        logic [31:0] w;
        bit          rdy, acc;
        int          budget;
        w = '0;
        for (int k = 0; k < tx_q.size(); k++) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = tx_q[k];
            budget = 400;
            acc    = 1'b0;
            while (!acc) begin
                rdy = bus.byte_ready;
                tick();
                acc = rdy;
                budget--;
                if (!acc && budget == 0) begin
                    check("byte_ready timeout", 32'd0, 32'd1);
                    bus.byte_valid = 1'b0;
                    return;
                end
            end
            w[(k % 4) * 8 +: 8] = tx_q[k];
            if (k % 4 == 3) begin
                check("wr_en after 4th byte", {31'd0, bus.wr_en}, 32'd1);
                check("wr_addr", {25'd0, bus.wr_addr}, k / 4);
                check("wr_data", bus.wr_data, w);
            end
            if (gap) begin
                bus.byte_valid = 1'b0;
                tick();
                if (k % 4 == 3) check("wr_en pulse width", {31'd0, bus.wr_en}, 32'd0);
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        while (!done && budget > 0) begin
            tick();
            budget--;
        end
        check("done reached", {31'd0, done}, 32'd1);
    endtask

    // First 128 logged writes must be the NOP sweep over addresses 0..127.
    task automatic check_clear_sweep();
        int bad = 0;
        if (log_a.size() < Depth) begin
            check("clear write count", log_a.size(), Depth);
            return;
        end
        for (int i = 0; i < Depth; i++) begin
            if (log_a[i] != AddrW'(i) || log_d[i] != NopWord) bad++;
        end
        check("clear sweep bad entries", bad, 0);
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wexp;
        int          bad;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;

        // Reset values.
        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("reset byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("reset pc_base", pc_base, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Reset mid-LOAD.
        start_load(32'h0000_0080, 2);
        tx_q = '{8'h33, 8'h82};
        send(1'b0);
        rst_ni = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("midreset byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("midreset pc_base", pc_base, 32'd0);
        check("midreset errs", {30'd0, err_ovf, err_align}, 32'd0);
        tick();
        rst_ni = 1'b1;
        clear_log();
        bus.byte_valid = 1'b1;
        repeat (10) tick();
        bus.byte_valid = 1'b0;
        check("post-reset writes", log_a.size(), 0);
        check("post-reset idle", {30'd0, busy, done}, 32'd0);

        // Basic two-word load.
        clear_log();
        start_load(32'h0, 2);
        tx_q = '{8'h33, 8'h82, 8'h20, 8'h00, 8'hB3, 8'h82, 8'h30, 8'h40};
        send(1'b0);
        tick();
        check("t2 write count", log_a.size(), 130);
        check_clear_sweep();
        if (log_a.size() >= 130) begin
            check("t2 w0 addr", {25'd0, log_a[128]}, 32'd0);
            check("t2 w0 data", log_d[128], 32'h0020_8233);
            check("t2 w1 addr", {25'd0, log_a[129]}, 32'd1);
            check("t2 w1 data", log_d[129], 32'h4030_82B3);
        end
        check("t2 done", {31'd0, done}, 32'd1);
        check("t2 busy", {31'd0, busy}, 32'd0);
        check("t2 wr_en idle", {31'd0, bus.wr_en}, 32'd0);
        check("t2 byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("t2 pc_base", pc_base, 32'd0);

        // Gapped stream.
        clear_log();
        start_load(32'h0000_0040, 2);
        send(1'b1);
        tick();
        check("t3 write count", log_a.size(), 130);
        if (log_a.size() >= 130) begin
            check("t3 w0 data", log_d[128], 32'h0020_8233);
            check("t3 w1 data", log_d[129], 32'h4030_82B3);
        end
        check("t3 pc_base", pc_base, 32'h0000_0040);

        // Empty program, misaligned base.
        clear_log();
        start_load(32'h0000_0103, 0);
        wait_done(300);
        tick();
        check("t4 write count", log_a.size(), Depth);
        check_clear_sweep();
        check("t4 err_align", {31'd0, err_align}, 32'd1);
        check("t4 err_overflow", {31'd0, err_ovf}, 32'd0);
        check("t4 pc_base", pc_base, 32'h0000_0100);

        // Oversized program clamps to Depth words.
        clear_log();
        start_load(32'h0, 200);
        check("t5 err_overflow", {31'd0, err_ovf}, 32'd1);
        check("t5 err_align cleared", {31'd0, err_align}, 32'd0);
        tx_q.delete();
        for (int w = 0; w < Depth; w++) begin
            tx_q.push_back(8'h13);
            tx_q.push_back(w[7:0]);
            tx_q.push_back(8'hC3);
            tx_q.push_back(w[7:0] ^ 8'h5A);
        end
        send(1'b0);
        tick();
        check("t5 write count", log_a.size(), 2 * Depth);
        bad = 0;
        if (log_a.size() >= 2 * Depth) begin
            for (int w = 0; w < Depth; w++) begin
                wexp = {w[7:0] ^ 8'h5A, 8'hC3, w[7:0], 8'h13};
                if (log_a[Depth + w] != AddrW'(w) || log_d[Depth + w] != wexp) bad++;
            end
        end
        check("t5 program bad entries", bad, 0);
        check("t5 done", {31'd0, done}, 32'd1);
        check("t5 byte_ready after done", {31'd0, bus.byte_ready}, 32'd0);

        // Restart from DONE; a start during CLEAR is ignored.
        clear_log();
        start_load(32'h0000_0004, 1);
        check("t6 done cleared", {31'd0, done}, 32'd0);
        check("t6 err_overflow cleared", {31'd0, err_ovf}, 32'd0);
        check("t6 busy", {31'd0, busy}, 32'd1);
        repeat (10) tick();
        start_load(32'h0000_0200, 3);
        tx_q = '{8'h93, 8'h00, 8'h10, 8'h00};
        send(1'b0);
        tick();
        check("t6 write count", log_a.size(), Depth + 1);
        check_clear_sweep();
        if (log_a.size() >= Depth + 1) begin
            check("t6 w0 data", log_d[Depth], 32'h0010_0093);
        end
        check("t6 pc_base kept", pc_base, 32'h0000_0004);
        check("t6 done", {31'd0, done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
